mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 clk  input  1  core clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 req_valid  input  1  MEM stage has a load/store; held stable while stallreq=1.
REQ-004 req_we  input  1  1=store, 0=load.
REQ-005 req_size  input  2  00=byte, 01=half, 10=word; 11 treated as word.
REQ-006 req_signed  input  1  load sign-extension select (lb/lh vs lbu/lhu).
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 stallreq  output  1  request pipeline stall (feeds stall bus bit for MEM).
REQ-010 resp_valid  output  1  one-cycle pulse: access complete.
REQ-011 resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-012 sram_req  output  1  SRAM request, held until sram_ack.
REQ-013 sram_wen  output  4  byte write enables; 0000 for loads.
REQ-014 sram_addr  output  32  word address (req_addr[31:2], low bits 00).
REQ-015 sram_wdata  output  32  store data replicated to selected lanes.
REQ-016 sram_ack  input  1  SRAM completion, single cycle, latency >=1 after sram_req.
REQ-017 sram_rdata  input  32  read word, valid with sram_ack.
REQ-018 addr_err  output  1  misaligned-access flag (only with MEM_ALIGN_CHECK_EN).

Function
REQ-019 FSM states IDLE, REQ, DONE, DRAIN; encoding in shared package.
REQ-020 IDLE: req_valid=1 -> REQ, latching we/size/signed/addr/wdata into request registers.
REQ-021 REQ: sram_req=1 with outputs from latched registers; on sram_ack -> DONE, latch sram_rdata for loads.
REQ-022 DONE: resp_valid=1 for exactly one cycle, then IDLE.
REQ-023 stallreq = req_valid & (state != DONE), combinational; back-to-back accesses cost min 3 cycles each.
REQ-024 Store byte enables: byte -> 0001<<addr[1:0]; half -> 0011<<{addr[1],0}; word -> 1111.
REQ-025 Store data: byte replicated x4, half replicated x2, word unchanged.
REQ-026 Load: select lane by addr[1:0]/addr[1], zero- or sign-extend per req_signed; word unchanged.
REQ-027 req_valid deasserted while in REQ (flush): transaction continues, state -> DRAIN; DRAIN holds sram_req until sram_ack, then IDLE with no resp_valid.
REQ-028 sram_ack in IDLE or DONE ignored.
REQ-029 Request registers update only on IDLE->REQ; req_* changes during REQ have no effect.

Reset
REQ-030 rst -> state IDLE, request registers 0, captured rdata 0.
REQ-031 During/after rst: stallreq follows REQ-023 (=req_valid), resp_valid=0, sram_req=0, sram_wen=0000, sram_addr=0, sram_wdata=0, resp_rdata=0, addr_err=0.
REQ-032 rst mid-transaction abandons it; a late sram_ack after reset is ignored per REQ-028.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=00 -> IDLE goes directly to DONE, no sram_req, addr_err=1 with resp_valid, resp_rdata=0.
REQ-034 Macro undefined: no check, addr_err tied 0, misaligned addresses use the lane rules of REQ-024/026.

Structure
REQ-035 Shared package: FSM state encoding, size codes (SZ_B/SZ_H/SZ_W), lane-select constants.
REQ-036 One sub-module mem_lane_fmt: combinational store enable/data formatting and load extension; FSM stays in mem_access_ctrl.

Verification
REQ-037 sw addr 0x100 wdata 0xDEADBEEF, ack after 2 cycles -> sram_wen=1111, sram_wdata=0xDEADBEEF, resp_valid on cycle 4 after req, stallreq drops same cycle.
REQ-038 sb addr 0x103 wdata 0x000000A5 -> sram_wen=1000, sram_addr=0x100, sram_wdata=0xA5A5A5A5.
REQ-039 lb addr 0x201 signed, sram_rdata=0x1234_80FF -> resp_rdata=0xFFFFFF80; lhu addr 0x202 same data -> 0x00001234.
REQ-040 Flush: lw issued, req_valid dropped in REQ, ack 3 cycles later -> no resp_valid, sram_req held until ack, then IDLE.
REQ-041 rst asserted while in REQ -> next cycle sram_req=0, state IDLE, late ack produces no response.
REQ-042 With MEM_ALIGN_CHECK_EN: lw addr 0x302 -> no sram_req, addr_err=1 and resp_valid next cycle; without macro -> normal access, addr_err=0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory access controller: FSM state
// encoding, access size codes, lane-select constants and the alignment helper.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StDone  = 2'b10,
    StDrain = 2'b11
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Byte-enable patterns for lane 0; shifted by the address offset.
  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  // Half needs addr[0]=0, word (and the 11 alias) needs addr[1:0]=00.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] off);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// MEM-stage request/response and SRAM bus bundle. The controller takes the
// slave view; the pipeline/SRAM side (or a bench) takes the master view.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        sram_req;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_ack;
  logic [31:0] sram_rdata;
  logic        addr_err;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  sram_ack, sram_rdata,
    output stallreq, resp_valid, resp_rdata,
    output sram_req, sram_wen, sram_addr, sram_wdata, addr_err
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output sram_ack, sram_rdata,
    input  stallreq, resp_valid, resp_rdata,
    input  sram_req, sram_wen, sram_addr, sram_wdata, addr_err
  );
endinterface

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting: store byte enables and data replication,
// load lane select with zero/sign extension.
module mem_lane_fmt
  import mem_access_ctrl_pkg::*;
(
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Decode size into enables, replicated store data and extended load data.
  always_comb begin
    byte_lane = rdata_i[{off_i, 3'b000} +: 8];
    half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    wen_o     = LANE_W;
    wdata_o   = wdata_i;
    rdata_o   = rdata_i;
    case (size_i)
      SZ_B: begin
        wen_o   = LANE_B << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      end
      SZ_H: begin
        wen_o   = LANE_H << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & half_lane[15]}}, half_lane};
      end
      default: begin
        wen_o   = LANE_W;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
    if (!we_i) begin
      wen_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: latches one access, runs the SRAM
// request/ack handshake and returns formatted load data.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mem_access_ctrl_if.slave bus
);

  state_e      state_q, state_d;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        err_d;
  logic        accept;

  logic [3:0]  fmt_wen;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_rdata;

`ifdef MEM_ALIGN_CHECK_EN
  assign err_d = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign err_d = 1'b0;
`endif

  assign accept = (state_q == StIdle) && bus.req_valid;

  mem_lane_fmt u_lane_fmt (
    .we_i     (we_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .off_i    (addr_q[1:0]),
    .wdata_i  (wdata_q),
    .rdata_i  (rdata_q),
    .wen_o    (fmt_wen),
    .wdata_o  (fmt_wdata),
    .rdata_o  (fmt_rdata)
  );

  // State, request registers (loaded only on accept) and captured read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        size_q   <= bus.req_size;
        signed_q <= bus.req_signed;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        err_q    <= err_d;
      end
      if ((state_q == StReq) && bus.sram_ack && !we_q) begin
        rdata_q <= bus.sram_rdata;
      end
    end
  end

  // Next state: a flushed request drains its SRAM access without responding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = err_d ? StDone : StReq;
        end
      end
      StReq: begin
        if (bus.sram_ack) begin
          state_d = bus.req_valid ? StDone : StIdle;
        end else if (!bus.req_valid) begin
          state_d = StDrain;
        end
      end
      StDone:  state_d = StIdle;
      StDrain: begin
        if (bus.sram_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; everything but stallreq is forced quiet while rst is high.
  always_comb begin
    logic busy;
    logic done;
    busy = !rst && ((state_q == StReq) || (state_q == StDrain));
    done = !rst && (state_q == StDone);
    bus.stallreq   = bus.req_valid && (state_q != StDone);
    bus.sram_req   = busy;
    bus.sram_wen   = busy ? fmt_wen : 4'b0000;
    bus.sram_addr  = busy ? {addr_q[31:2], 2'b00} : 32'h0;
    bus.sram_wdata = busy ? fmt_wdata : 32'h0;
    bus.resp_valid = done;
    bus.addr_err   = done && err_q;
    bus.resp_rdata = (done && !we_q && !err_q) ? fmt_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model,
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc = 0;
  logic chk_en = 1'b0;

  logic        exp_stall = 1'b0, exp_sreq = 1'b0, exp_resp = 1'b0, exp_err = 1'b0;
  logic        exp_load = 1'b0;
  logic [3:0]  exp_wen = 4'h0;
  logic [31:0] exp_saddr = 32'h0, exp_swdata = 32'h0, exp_rdata = 32'h0;

  logic [3:0]  obs_wen = 4'h0;
  logic [31:0] obs_saddr = 32'h0, obs_swdata = 32'h0, obs_rdata = 32'h0;
  logic        obs_err = 1'b0;
  int          obs_resp_cyc = 0, obs_resp_cnt = 0, obs_sreq_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_size(input logic [1:0] size);
    return (size == 2'b11) ? 2 : int'(size);
  endfunction

  function automatic logic [3:0] m_wen(input logic we, input logic [1:0] size,
                                       input logic [31:0] addr);
    int off;
    off = int'(addr & 32'd3);
    if (!we) return 4'h0;
    if (eff_size(size) == 0) return 4'(1 << off);
    if (eff_size(size) == 1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (eff_size(size) == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (eff_size(size) == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] rd);
    logic [31:0] v;
    int off;
    off = int'(addr & 32'd3);
    if (eff_size(size) == 0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (eff_size(size) == 1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  function automatic bit m_misal(input logic [1:0] size, input logic [31:0] addr);
    if (eff_size(size) == 1) return (addr % 2) != 0;
    if (eff_size(size) == 2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) obs_resp_cnt++;
    if (bus.sram_req === 1'b1) obs_sreq_cnt++;
    if (chk_en) begin
      chk("stallreq", 32'(bus.stallreq), 32'(exp_stall));
      chk("sram_req", 32'(bus.sram_req), 32'(exp_sreq));
      chk("resp_valid", 32'(bus.resp_valid), 32'(exp_resp));
      chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
      if (exp_sreq) begin
        chk("sram_wen", 32'(bus.sram_wen), 32'(exp_wen));
        chk("sram_addr", bus.sram_addr, exp_saddr);
        if (exp_wen != 4'h0) chk("sram_wdata", bus.sram_wdata, exp_swdata);
        obs_wen    = bus.sram_wen;
        obs_saddr  = bus.sram_addr;
        obs_swdata = bus.sram_wdata;
      end
      if (exp_resp) begin
        obs_resp_cyc = cyc;
        obs_rdata    = bus.resp_rdata;
        obs_err      = bus.addr_err;
        if (exp_load) chk("resp_rdata", bus.resp_rdata, exp_rdata);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic set_exp(input logic st, input logic sr, input logic rv, input logic er);
    exp_stall = st;
    exp_sreq  = sr;
    exp_resp  = rv;
    exp_err   = er;
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) begin
      step();
      bus.req_valid  = 1'b0;
      bus.sram_ack   = spur ? 1'($urandom) : 1'b0;
      bus.sram_rdata = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One access; ack arrives lat cycles after sram_req rises; flush_at>0 drops
  // req_valid on that REQ cycle (must be <= lat).
  task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int lat, input int flush_at,
                        input bit scramble);
    bit misal;
    misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = m_misal(size, addr);
`endif
    step();
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.sram_ack   = 1'b0;
    bus.sram_rdata = $urandom;
    issue_cyc  = cyc;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    exp_wen    = m_wen(we, size, addr);
    exp_saddr  = addr & 32'hFFFF_FFFC;
    exp_swdata = m_wdata(size, wdata);
    if (misal) begin
      step();
      bus.sram_ack = 1'($urandom);
      set_exp(1'b0, 1'b0, 1'b1, 1'b1);
      exp_load  = 1'b1;
      exp_rdata = 32'h0;
    end else begin
      for (int k = 1; k <= lat + 1; k++) begin
        step();
        if (flush_at == k) bus.req_valid = 1'b0;
        if (scramble) begin
          bus.req_we     = 1'($urandom);
          bus.req_size   = 2'($urandom);
          bus.req_signed = 1'($urandom);
          bus.req_addr   = $urandom;
          bus.req_wdata  = $urandom;
        end
        bus.sram_ack   = (k == lat + 1);
        bus.sram_rdata = (k == lat + 1) ? rd : $urandom;
        set_exp(bus.req_valid, 1'b1, 1'b0, 1'b0);
      end
      if (flush_at == 0) begin
        step();
        bus.sram_ack   = 1'($urandom);
        bus.sram_rdata = $urandom;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0);
        exp_load  = !we;
        exp_rdata = m_load(size, sgn, addr, rd);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int cnt0;
    int sreq0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.sram_ack   = 1'b0;
    bus.sram_rdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset: stallreq tracks req_valid, all other outputs zero.
    step();
    bus.req_valid = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    settle();
    chk("rst_wen", 32'(bus.sram_wen), 32'h0);
    chk("rst_addr", bus.sram_addr, 32'h0);
    chk("rst_wdata", bus.sram_wdata, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    step();
    rst = 1'b0;
    bus.req_valid = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("post_rst_addr", bus.sram_addr, 32'h0);
    chk("post_rst_wdata", bus.sram_wdata, 32'h0);

    // sw 0x100, ack two cycles after sram_req rises.
    do_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 2, 0, 1'b0);
    settle();
    chk("sw_wen", 32'(obs_wen), 32'hF);
    chk("sw_wdata", obs_swdata, 32'hDEAD_BEEF);
    chk("sw_resp_cycle", 32'(obs_resp_cyc - issue_cyc), 32'd4);

    // sb 0x103, back-to-back with the previous access.
    do_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 1, 0, 1'b1);
    settle();
    chk("sb_wen", 32'(obs_wen), 32'h8);
    chk("sb_addr", obs_saddr, 32'h100);
    chk("sb_wdata", obs_swdata, 32'hA5A5_A5A5);
    idle(1, 1'b1);

    do_txn(1'b0, 2'b00, 1'b1, 32'h201, 32'h0, 32'h1234_80FF, 1, 0, 1'b0);
    settle();
    chk("lb_rdata", obs_rdata, 32'hFFFF_FF80);
    do_txn(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h1234_80FF, 3, 0, 1'b0);
    settle();
    chk("lhu_rdata", obs_rdata, 32'h0000_1234);
    idle(2, 1'b0);

    // Flush: lw dropped on the first REQ cycle, ack three cycles later.
    cnt0  = obs_resp_cnt;
    sreq0 = obs_sreq_cnt;
    do_txn(1'b0, 2'b10, 1'b0, 32'h180, 32'h0, 32'h5555_AAAA, 3, 1, 1'b0);
    settle();
    chk("flush_sreq_cycles", 32'(obs_sreq_cnt - sreq0), 32'd4);
    idle(2, 1'b1);
    chk("flush_no_resp", 32'(obs_resp_cnt - cnt0), 32'd0);

    // Reset in the middle of a request; late ack afterwards is ignored.
    cnt0 = obs_resp_cnt;
    step();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h400;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0);
    exp_wen   = 4'h0;
    exp_saddr = 32'h400;
    step();
    set_exp(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk_en = 1'b0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("rst_mid_sreq", 32'(bus.sram_req), 32'h0);
    chk("rst_mid_addr", bus.sram_addr, 32'h0);
    step();
    bus.sram_ack = 1'b1;
    step();
    bus.sram_ack = 1'b0;
    settle();
    chk("rst_late_ack", 32'(obs_resp_cnt - cnt0), 32'd0);

    // Misaligned word load.
    sreq0 = obs_sreq_cnt;
    do_txn(1'b0, 2'b10, 1'b0, 32'h302, 32'h0, 32'hCAFE_F00D, 1, 0, 1'b0);
    settle();
`ifdef MEM_ALIGN_CHECK_EN
    chk("misal_err", 32'(obs_err), 32'h1);
    chk("misal_no_sreq", 32'(obs_sreq_cnt - sreq0), 32'd0);
    chk("misal_rdata", obs_rdata, 32'h0);
`else
    chk("misal_err", 32'(obs_err), 32'h0);
    chk("misal_addr", obs_saddr, 32'h300);
    chk("misal_rdata", obs_rdata, 32'hCAFE_F00D);
`endif
    idle(1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      int lat;
      int fl;
      lat = int'($urandom_range(1, 4));
      fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, lat)) : 0;
      do_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             lat, fl, 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)), 1'b1);
    end
    idle(2, 1'b0);
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
